seq_mul_ctrl: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 23 ++
 rtl/seq_mul_iter_cnt.sv | 49 ++++
 rtl/seq_mul_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_seq_mul_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul_pkg
//
// Shared definitions for the repeated-addition multiplier controller.
//
// Contents:
//   WIDTH_DEFAULT - default operand width (product is 2*WIDTH on the datapath)
//   state_t       - controller state encoding (IDLE, LOAD, ACCUM, DONE)
// ---------------------------------------------------------------------------
package seq_mul_pkg;

    // Default operand width used by the controller and its iteration counter.
    localparam int WIDTH_DEFAULT = 2;

    // Controller states. IDLE is zero so a reset register reads as IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_mul_iter_cnt.sv
// ---------------------------------------------------------------------------
// seq_mul_iter_cnt
//
// Loadable WIDTH-bit down counter holding the number of accumulate cycles
// still to run.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (value -> 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   value to load
//   dec      in   decrement by one (saturates at zero)
//   value    out  current count
//   last     out  value == 1 (the current accumulate cycle is the final one)
//   is_zero  out  value == 0
// ---------------------------------------------------------------------------
module seq_mul_iter_cnt
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             last,
    output logic             is_zero
);

    // Count register. A load always wins so a fresh operation never inherits
    // a pending decrement. Decrementing stops at zero so a stray dec can
    // never wrap the count back to the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    // Status decode used by the controller to pick its exit cycle.
    assign last    = (value == WIDTH'(1));
    assign is_zero = (value == '0);

endmodule

// File: rtl/seq_mul_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mul_ctrl
//
// Control FSM for a repeated-addition sequential multiplier. On an accepted
// start it loads the operands and clears the product (LOAD, one cycle), then
// issues op_b accumulate cycles (ACCUM), then raises done until the
// consumer acknowledges it (DONE). All datapath strobes are Moore outputs
// decoded from the state register.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request a multiply (accepted only while ready)
//   op_b      in   multiplier value, sets the number of accumulate cycles
//   abort     in   cancel an operation in LOAD or ACCUM
//   zero      in   datapath flag: B register has reached zero
//   done_ack  in   consumer acknowledge of done
//   ready     out  controller idle, start will be accepted
//   busy      out  operation in progress (LOAD or ACCUM)
//   loadA     out  load operand A register
//   loadB     out  load operand B register
//   clear     out  clear product register
//   decB      out  decrement B register
//   loadF     out  accumulate into product register
//   done      out  result valid, held until done_ack
//   err       out  sticky: datapath zero flag disagreed with the count
// ---------------------------------------------------------------------------
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    input  logic             zero,
    input  logic             done_ack,
    output logic             ready,
    output logic             busy,
    output logic             loadA,
    output logic             loadB,
    output logic             clear,
    output logic             decB,
    output logic             loadF,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             cnt_dec;
    logic [WIDTH-1:0] cnt;
    logic             cnt_last;
    logic             cnt_zero;
    logic             chk_pend;
    logic             chk_pend_next;

    // A start is only taken while idle; op_b is captured on that same edge
    // so later changes on op_b cannot affect the running operation.
    assign accept  = (state == IDLE) && start;
    assign cnt_dec = (state == ACCUM);

    seq_mul_iter_cnt #(
        .WIDTH (WIDTH)
    ) u_iter_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (op_b),
        .dec      (cnt_dec),
        .value    (cnt),
        .last     (cnt_last),
        .is_zero  (cnt_zero)
    );

    // State register plus the one-cycle marker that tells the DONE state it
    // has just arrived from ACCUM and must compare the datapath zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            chk_pend <= 1'b0;
        end else begin
            state    <= state_next;
            chk_pend <= chk_pend_next;
        end
    end

    // Next-state logic. abort is only honoured in LOAD and ACCUM and beats
    // the normal transition taken in the same cycle. In ACCUM the exit is
    // taken on the cycle where one iteration remains; a zero count is also
    // treated as an exit so the FSM can never sit in ACCUM forever.
    always_comb begin
        state_next    = state;
        chk_pend_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt_zero) begin
                    state_next = DONE;
                end else begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt_last || (cnt == '0)) begin
                    state_next    = DONE;
                    chk_pend_next = 1'b1;
                end
            end
            DONE: begin
                if (done_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore output decode. Every output is a pure function of the state so
    // nothing glitches with the request-side inputs, and IDLE/DONE never
    // drive a datapath strobe.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        loadA = 1'b0;
        loadB = 1'b0;
        clear = 1'b0;
        decB  = 1'b0;
        loadF = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            LOAD: begin
                busy  = 1'b1;
                loadA = 1'b1;
                loadB = 1'b1;
                clear = 1'b1;
            end
            ACCUM: begin
                busy  = 1'b1;
                decB  = 1'b1;
                loadF = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // Sticky error flag. After op_b accumulate cycles the B register must
    // read zero during the first DONE cycle; any disagreement is latched
    // until the next accepted start. A zero-length multiply skips ACCUM, so
    // chk_pend is never set and no comparison is made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if ((state == DONE) && chk_pend && !zero) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_mul_ctrl
//
// Self-checking bench for seq_mul_ctrl. Directed scenario tasks followed by
// a randomized run checked against a cycle-position reference model: after
// an accept, sample 0 is LOAD, samples 1..op_b are ACCUM, the rest are DONE
// until acknowledged, unless an abort returns to IDLE.
// Output vector layout: {ready,busy,loadA,loadB,clear,decB,loadF,done,err}.
// ---------------------------------------------------------------------------
module tb_seq_mul_ctrl;
    import seq_mul_pkg::*;

    localparam int W = 2;

    typedef enum int {P_IDLE, P_LOAD, P_ACCUM, P_DONE} phase_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_b;
    logic         abort;
    logic         zero;
    logic         done_ack;
    logic         ready;
    logic         busy;
    logic         loadA;
    logic         loadB;
    logic         clear;
    logic         decB;
    logic         loadF;
    logic         done;
    logic         err;

    int checks;
    int passed;

    seq_mul_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_b     (op_b),
        .abort    (abort),
        .zero     (zero),
        .done_ack (done_ack),
        .ready    (ready),
        .busy     (busy),
        .loadA    (loadA),
        .loadB    (loadB),
        .clear    (clear),
        .decB     (decB),
        .loadF    (loadF),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "[TB] time limit");
    end

    function automatic logic [8:0] outs();
        return {ready, busy, loadA, loadB, clear, decB, loadF, done, err};
    endfunction

    // Expected outputs from the operation phase and the modelled err flag.
    function automatic logic [8:0] exp_vec(phase_t p, logic e);
        case (p)
            P_IDLE:  return {1'b1, 7'b0000000, e};
            P_LOAD:  return {2'b01, 3'b111, 2'b00, 1'b0, e};
            P_ACCUM: return {2'b01, 3'b000, 2'b11, 1'b0, e};
            default: return {2'b00, 3'b000, 2'b00, 1'b1, e};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset state, release, and an asynchronous reset in the 2nd ACCUM cycle.
    task automatic test_reset();
        int nd;
        int ndec;
        logic [8:0] tr;
        rst_n = 1'b0; start = 1'b0; op_b = '0; abort = 1'b0;
        zero = 1'b0; done_ack = 1'b0;
        #3;
        checks++;
        if (outs() !== exp_vec(P_IDLE, 1'b0))
            $display("[TB] FAIL reset_state: got %b want %b", outs(), exp_vec(P_IDLE, 1'b0));
        else passed++;
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++;
        if (outs() !== exp_vec(P_IDLE, 1'b0))
            $display("[TB] FAIL reset_release: got %b want %b", outs(), exp_vec(P_IDLE, 1'b0));
        else passed++;
        start = 1'b1; op_b = 2'd3;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== exp_vec(P_IDLE, 1'b0))
            $display("[TB] FAIL reset_mid_accum: got %b want %b", outs(), exp_vec(P_IDLE, 1'b0));
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        nd = 0; ndec = 0;
        repeat (8) begin
            step();
            tr = outs();
            nd += int'(tr[1]);
            ndec += int'(tr[3]);
        end
        checks++;
        if (nd != 0 || ndec != 0)
            $display("[TB] FAIL reset_no_done: got done=%0d decB=%0d cycles want 0/0", nd, ndec);
        else passed++;
    endtask

    // op_b=3 with zero high exactly in the first DONE cycle.
    task automatic test_basic();
        int nl, nd, fd;
        logic [8:0] tr;
        nl = 0; nd = 0; fd = -1;
        start = 1'b1; op_b = 2'd3; zero = 1'b0;
        step();
        start = 1'b0; op_b = 2'd1;
        for (int i = 0; i < 7; i++) begin
            tr = outs();
            nl += int'(tr[6]);
            nd += int'(tr[3]);
            if (tr[1] && fd < 0) fd = i;
            zero = (i == 4);
            step();
        end
        zero = 1'b0;
        checks++;
        if (nl != 1) $display("[TB] FAIL basic_load_cycles: got %0d want 1", nl); else passed++;
        checks++;
        if (nd != 3) $display("[TB] FAIL basic_decB_cycles: got %0d want 3", nd); else passed++;
        checks++;
        if (fd != 4) $display("[TB] FAIL basic_done_at: got %0d want 4", fd); else passed++;
        checks++;
        if (outs() !== exp_vec(P_DONE, 1'b0))
            $display("[TB] FAIL basic_done_held: got %b want %b", outs(), exp_vec(P_DONE, 1'b0));
        else passed++;
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
        checks++;
        if (outs() !== exp_vec(P_IDLE, 1'b0))
            $display("[TB] FAIL basic_ack_ready: got %b want %b", outs(), exp_vec(P_IDLE, 1'b0));
        else passed++;
    endtask

    // op_b=0: LOAD then straight to DONE, no accumulate, no zero check.
    task automatic test_zero_opb();
        int nl, nd, fd;
        logic [8:0] tr;
        nl = 0; nd = 0; fd = -1;
        start = 1'b1; op_b = 2'd0; zero = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tr = outs();
            nl += int'(tr[4]);
            nd += int'(tr[2]);
            if (tr[1] && fd < 0) fd = i;
            step();
        end
        checks++;
        if (nl != 1 || nd != 0 || fd != 1)
            $display("[TB] FAIL zero_opb: got clear=%0d loadF=%0d done_at=%0d want 1/0/1", nl, nd, fd);
        else passed++;
        checks++;
        if (outs() !== exp_vec(P_DONE, 1'b0))
            $display("[TB] FAIL zero_opb_err: got %b want %b", outs(), exp_vec(P_DONE, 1'b0));
        else passed++;
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
    endtask

    // op_b=2 with zero held low: err set, sticky until the next accept.
    task automatic test_err();
        int fd;
        logic [8:0] tr;
        fd = -1;
        start = 1'b1; op_b = 2'd2; zero = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tr = outs();
            if (tr[1] && fd < 0) fd = i;
            step();
        end
        checks++;
        if (fd != 3) $display("[TB] FAIL err_done_at: got %0d want 3", fd); else passed++;
        checks++;
        if (outs() !== exp_vec(P_DONE, 1'b1))
            $display("[TB] FAIL err_set: got %b want %b", outs(), exp_vec(P_DONE, 1'b1));
        else passed++;
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
        repeat (3) step();
        checks++;
        if (outs() !== exp_vec(P_IDLE, 1'b1))
            $display("[TB] FAIL err_sticky: got %b want %b", outs(), exp_vec(P_IDLE, 1'b1));
        else passed++;
        start = 1'b1; op_b = 2'd1; zero = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (outs() !== exp_vec(P_LOAD, 1'b0))
            $display("[TB] FAIL err_clear_on_accept: got %b want %b", outs(), exp_vec(P_LOAD, 1'b0));
        else passed++;
        step();
        step();
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
        checks++;
        if (outs() !== exp_vec(P_IDLE, 1'b0))
            $display("[TB] FAIL err_good_op: got %b want %b", outs(), exp_vec(P_IDLE, 1'b0));
        else passed++;
    endtask

    // op_b=3, abort in the first ACCUM cycle.
    task automatic test_abort();
        int nd, ndone;
        logic [8:0] tr;
        nd = 0; ndone = 0;
        start = 1'b1; op_b = 2'd3; zero = 1'b0;
        step();
        start = 1'b0;
        tr = outs();
        nd += int'(tr[3]);
        step();
        tr = outs();
        nd += int'(tr[3]);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (outs() !== exp_vec(P_IDLE, 1'b0))
            $display("[TB] FAIL abort_to_idle: got %b want %b", outs(), exp_vec(P_IDLE, 1'b0));
        else passed++;
        repeat (6) begin
            tr = outs();
            nd += int'(tr[3]);
            ndone += int'(tr[1]);
            step();
        end
        checks++;
        if (nd != 1 || ndone != 0)
            $display("[TB] FAIL abort_counts: got decB=%0d done=%0d want 1/0", nd, ndone);
        else passed++;
    endtask

    // start held high, op_b=1, ack delayed so done is held 4 cycles each op.
    task automatic test_back_to_back();
        int dec1, dec2, dn1, dn2, nl;
        logic r6, r13;
        logic [8:0] tr;
        dec1 = 0; dec2 = 0; dn1 = 0; dn2 = 0; nl = 0; r6 = 1'b0; r13 = 1'b0;
        start = 1'b1; op_b = 2'd1; zero = 1'b1; done_ack = 1'b0;
        step();
        for (int i = 0; i < 14; i++) begin
            tr = outs();
            nl += int'(tr[6]);
            if (i < 7) begin
                dec1 += int'(tr[3]);
                dn1  += int'(tr[1]);
            end else begin
                dec2 += int'(tr[3]);
                dn2  += int'(tr[1]);
            end
            if (i == 6)  r6  = tr[8];
            if (i == 13) r13 = tr[8];
            done_ack = (i == 5) || (i == 12);
            if (i == 12) start = 1'b0;
            step();
        end
        done_ack = 1'b0;
        checks++;
        if (dec1 != 1 || dec2 != 1)
            $display("[TB] FAIL b2b_decB: got %0d/%0d want 1/1", dec1, dec2);
        else passed++;
        checks++;
        if (dn1 != 4 || dn2 != 4)
            $display("[TB] FAIL b2b_done_held: got %0d/%0d want 4/4", dn1, dn2);
        else passed++;
        checks++;
        if (nl != 2 || r6 !== 1'b1 || r13 !== 1'b1)
            $display("[TB] FAIL b2b_accepts: got loads=%0d ready6=%b ready13=%b want 2/1/1", nl, r6, r13);
        else passed++;
    endtask

    // Randomized operations against the cycle-position model.
    task automatic test_random();
        phase_t ph;
        logic   err_m;
        logic   set_err;
        int     b, abort_at, ack_delay, dcnt, i;
        logic   zv;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        err_m = 1'b0;
        for (int n = 0; n < 150; n++) begin
            b         = $urandom_range(0, 3);
            abort_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, b) : -1;
            ack_delay = $urandom_range(0, 3);
            zv        = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                start = 1'b0; abort = 1'($urandom); done_ack = 1'($urandom);
                zero = 1'($urandom); op_b = W'($urandom);
                step();
                checks++;
                if (outs() !== exp_vec(P_IDLE, err_m))
                    $display("[TB] FAIL rand_idle op%0d: got %b want %b", n, outs(), exp_vec(P_IDLE, err_m));
                else passed++;
            end
            start = 1'b1; op_b = W'(b); abort = 1'($urandom);
            done_ack = 1'($urandom); zero = 1'($urandom);
            step();
            err_m = 1'b0;
            i = 0;
            dcnt = 0;
            forever begin
                ph = (i == 0) ? P_LOAD : ((i <= b) ? P_ACCUM : P_DONE);
                checks++;
                if (outs() !== exp_vec(ph, err_m))
                    $display("[TB] FAIL rand_op%0d cyc%0d: got %b want %b", n, i, outs(), exp_vec(ph, err_m));
                else passed++;
                op_b = W'($urandom); zero = 1'($urandom); start = 1'($urandom);
                abort = 1'($urandom); done_ack = 1'($urandom);
                set_err = 1'b0;
                if (ph == P_DONE) begin
                    if (dcnt == 0) begin
                        zero = zv;
                        set_err = (b > 0) && !zv;
                    end
                    if (dcnt == ack_delay) begin
                        done_ack = 1'b1;
                        start = 1'b0;
                        step();
                        if (set_err) err_m = 1'b1;
                        break;
                    end
                    done_ack = 1'b0;
                    dcnt++;
                end else if (i == abort_at) begin
                    abort = 1'b1;
                    start = 1'b0;
                    step();
                    break;
                end else begin
                    abort = 1'b0;
                end
                step();
                if (set_err) err_m = 1'b1;
                i++;
            end
            start = 1'b0; abort = 1'b0; done_ack = 1'b0;
            checks++;
            if (outs() !== exp_vec(P_IDLE, err_m))
                $display("[TB] FAIL rand_end op%0d: got %b want %b", n, outs(), exp_vec(P_IDLE, err_m));
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_zero_opb();
        test_err();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
